cfg_switch_block: RTL and testbench
===================================

Name: cfg_switch_block

Overview:
- Parametrised, configurable switch block for the routing fabric. Successor to the fixed three-side, three-track bidirectional switch block.
- Connects W tracks on four sides (left, right, top, bottom) through per-output source muxes.
- Configuration arrives over a serial shift chain into a shadow register. It moves to the active register only on a validated commit, so a partially loaded configuration never disturbs live routing.
- Tiles daisy-chain via cfg_out -> cfg_in.

Parameters:
- W, 3, tracks per side.
- REG_OUT, 0, 0 = outputs combinational from the active config; 1 = outputs registered (1-cycle latency).
- CFG_BITS, 8*W (derived localparam, not overridable), config bits: 4 sides x W tracks x 2-bit select.

Ports:
- clk  input  1  fabric clock
- rst_n  input  1  asynchronous active-low reset
- cfg_in  input  1  serial configuration data
- cfg_en  input  1  shift enable
- cfg_commit  input  1  single-cycle pulse: copy shadow to active
- cfg_out  output  1  serial scan-out to the next tile
- cfg_full  output  1  high when exactly CFG_BITS bits have been shifted since the last commit or reset
- cfg_err  output  1  sticky: a commit was attempted with an incomplete load
- in_l, in_r, in_t, in_b  input  W  track inputs per side
- out_l, out_r, out_t, out_b  output  W  track outputs per side

Behaviour:
- Reset (async, rst_n=0): shadow=0, active=0, bit counter=0, cfg_err=0. All out_* = 0 immediately, including the REG_OUT=1 output flops. cfg_out=0, cfg_full=0.
- Side index: L=0, R=1, T=2, B=3.
- Field layout: the field for output side s, track i occupies active[2*(s*W+i)+1 : 2*(s*W+i)].
- Select codes:
  - 0 = off; output is 0.
  - 1, 2, 3 = the track-i input of the other three sides, in ascending side index with s excluded.
    - L: 1=R, 2=T, 3=B.
    - R: 1=L, 2=T, 3=B.
    - T: 1=L, 2=R, 3=B.
    - B: 1=L, 2=R, 3=T.
  - Track index is preserved (disjoint topology). There is no cross-track switching.
- Loopback: an input never routes back to its own side's output. Cycles through a neighbouring tile are the configurer's responsibility.
- Shift: on a clk edge with cfg_en=1 and cfg_commit=0:
  - shadow <= {shadow[CFG_BITS-2:0], cfg_in}.
  - The first bit shifted lands at shadow[CFG_BITS-1] after CFG_BITS shifts, so the stream is sent MSB first.
  - The counter increments and saturates at CFG_BITS. Further shifts keep shifting data while the counter stays at CFG_BITS.
- cfg_out = shadow[CFG_BITS-1] (registered). A bit entering cfg_in appears on cfg_out after CFG_BITS shifts.
- cfg_full = (counter == CFG_BITS).
- Commit: on a clk edge with cfg_commit=1:
  - If the counter == CFG_BITS: active <= shadow, counter <= 0, cfg_err <= 0. Shadow is retained.
  - Otherwise: active is unchanged, counter is unchanged, cfg_err <= 1.
- Simultaneous cfg_en and cfg_commit: commit has priority, and no shift occurs that cycle.
- Routing latency:
  - REG_OUT=0: out_* follow in_* combinationally. A new config takes effect in the cycle after the commit edge.
  - REG_OUT=1: out_* are sampled at each clk edge from the mux result, adding one cycle of latency relative to REG_OUT=0.
- Reset mid-shift or mid-commit: everything returns to reset values. A partial load is discarded, and a commit must follow a fresh full load.
- cfg_err clears only on a successful commit or on reset.

Test Plan:
1. Reset, then drive all in_*=all-ones -> all out_*=0, cfg_full=0, cfg_err=0.
2. W=3: shift 24 bits setting only the out_r track-0 field=1 (from L), then commit. Drive in_l[0]=0 then 1 -> out_r[0]=0 then 1; all other out_* bits remain 0; cfg_full drops to 0 after the commit.
3. Shift 10 bits, then commit -> cfg_err=1 and routing unchanged. Finish the remaining 14 bits and commit -> cfg_err=0 and the new routing is active.
4. Shift a 48-bit pattern continuously -> cfg_out reproduces bits 0..23 on shifts 25..48; cfg_full is held at 1 from shift 24 onward.
5. Assert cfg_en and cfg_commit together after a full load -> active updates, and shadow equals the pre-edge value (no shift).
6. REG_OUT=1 with out_b[2] routed from in_t[2] (code 3): toggle in_t[2] -> out_b[2] follows one cycle later. Assert rst_n low mid-shift -> out_* go to 0 asynchronously, and the counter and cfg_err read 0.

Source files
------------

// File: rtl/cfg_switch_block_if.sv
// Configuration chain and track buses of the switch block.
// The master side drives config and track inputs; the slave is the block.
interface cfg_switch_block_if #(
   parameter int W = 3
) ();
   logic         cfg_in;
   logic         cfg_en;
   logic         cfg_commit;
   logic         cfg_out;
   logic         cfg_full;
   logic         cfg_err;
   logic [W-1:0] in_l;
   logic [W-1:0] in_r;
   logic [W-1:0] in_t;
   logic [W-1:0] in_b;
   logic [W-1:0] out_l;
   logic [W-1:0] out_r;
   logic [W-1:0] out_t;
   logic [W-1:0] out_b;

   modport master (
      output cfg_in, cfg_en, cfg_commit,
      output in_l, in_r, in_t, in_b,
      input  cfg_out, cfg_full, cfg_err,
      input  out_l, out_r, out_t, out_b
   );

   modport slave (
      input  cfg_in, cfg_en, cfg_commit,
      input  in_l, in_r, in_t, in_b,
      output cfg_out, cfg_full, cfg_err,
      output out_l, out_r, out_t, out_b
   );
endinterface

// File: rtl/cfg_switch_block.sv
// Configurable four-side switch block with shadow/active config chain.
// Each output track picks the same-index track of one of the other sides.
module cfg_switch_block #(
   parameter int W       = 3,
   parameter int REG_OUT = 0
) (
   input logic               clk,
   input logic               rst_n,
   cfg_switch_block_if.slave bus
);
   localparam int CB = 8 * W;
   localparam int CW = $clog2(CB + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(CB);

   logic [CB-1:0]  shadow_q, shadow_d;
   logic [CB-1:0]  active_q, active_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           err_q, err_d;
   logic           full;
   logic [4*W-1:0] ins_all;
   logic [4*W-1:0] mux_d;
   logic [4*W-1:0] route;

   assign full    = (cnt_q == CNT_MAX);
   assign ins_all = {bus.in_b, bus.in_t, bus.in_r, bus.in_l};

   // Commit beats shift; a short load only raises the sticky error.
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      if (bus.cfg_commit) begin
         if (full) begin
            active_d = shadow_q;
            cnt_d    = '0;
            err_d    = 1'b0;
         end else begin
            err_d = 1'b1;
         end
      end else if (bus.cfg_en) begin
         shadow_d = {shadow_q[CB-2:0], bus.cfg_in};
         if (!full) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Config chain state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
         active_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   // Codes 1..3 walk the other sides in ascending order, skipping own side.
   for (genvar s = 0; s < 4; s++) begin : g_side
      localparam int S1 = (s == 0) ? 1 : 0;
      localparam int S2 = (s <= 1) ? 2 : 1;
      localparam int S3 = (s <= 2) ? 3 : 2;
      for (genvar i = 0; i < W; i++) begin : g_trk
         localparam int F = 2 * (s * W + i);
         logic [1:0] sel;
         assign sel = active_q[F+1:F];
         assign mux_d[s*W+i] =
            (sel == 2'd1) ? ins_all[S1*W+i] :
            (sel == 2'd2) ? ins_all[S2*W+i] :
            (sel == 2'd3) ? ins_all[S3*W+i] :
                            1'b0;
      end
   end

   if (REG_OUT != 0) begin : g_reg
      logic [4*W-1:0] out_q;
      // Registered routing result, cleared with the config.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            out_q <= '0;
         end else begin
            out_q <= mux_d;
         end
      end
      assign route = out_q;
   end else begin : g_comb
      assign route = mux_d;
   end

   assign bus.out_l    = route[0*W +: W];
   assign bus.out_r    = route[1*W +: W];
   assign bus.out_t    = route[2*W +: W];
   assign bus.out_b    = route[3*W +: W];
   assign bus.cfg_out  = shadow_q[CB-1];
   assign bus.cfg_full = full;
   assign bus.cfg_err  = err_q;
endmodule

// File: tb/tb_cfg_switch_block.sv
// Bench for cfg_switch_block: comb and registered variants side by side.
// A bit-level model of the config chain and routing table is compared each cycle.
module tb_cfg_switch_block;
   localparam int W  = 3;
   localparam int CB = 8 * W;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic cfg_in = 1'b0;
   logic cfg_en = 1'b0;
   logic cfg_commit = 1'b0;
   logic [W-1:0] in_l = '0;
   logic [W-1:0] in_r = '0;
   logic [W-1:0] in_t = '0;
   logic [W-1:0] in_b = '0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cfg_switch_block_if #(.W(W)) if0 ();
   cfg_switch_block_if #(.W(W)) if1 ();

   assign if0.cfg_in     = cfg_in;
   assign if0.cfg_en     = cfg_en;
   assign if0.cfg_commit = cfg_commit;
   assign if0.in_l       = in_l;
   assign if0.in_r       = in_r;
   assign if0.in_t       = in_t;
   assign if0.in_b       = in_b;
   assign if1.cfg_in     = cfg_in;
   assign if1.cfg_en     = cfg_en;
   assign if1.cfg_commit = cfg_commit;
   assign if1.in_l       = in_l;
   assign if1.in_r       = in_r;
   assign if1.in_t       = in_t;
   assign if1.in_b       = in_b;

   cfg_switch_block #(.W(W), .REG_OUT(0)) u_comb (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if0.slave)
   );

   cfg_switch_block #(.W(W), .REG_OUT(1)) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1.slave)
   );

   // Model state: shift register as bits, active table, load count.
   bit [CB-1:0]    m_sh  = '0;
   bit [CB-1:0]    m_act = '0;
   int             m_cnt = 0;
   bit             m_err = 1'b0;
   logic [4*W-1:0] m_reg = '0;

   // Source side for each (output side, code-1): L=0 R=1 T=2 B=3.
   int src_tbl [4][3] = '{'{1, 2, 3}, '{0, 2, 3}, '{0, 1, 3}, '{0, 1, 2}};

   function automatic logic [4*W-1:0] ins_vec();
      return {in_b, in_t, in_r, in_l};
   endfunction

   function automatic logic [4*W-1:0] route_all(
      bit [CB-1:0] act, logic [4*W-1:0] ins);
      logic [4*W-1:0] r;
      int c;
      r = '0;
      for (int s = 0; s < 4; s++) begin
         for (int i = 0; i < W; i++) begin
            c = int'(act[2*(s*W+i) +: 2]);
            if (c != 0) r[s*W+i] = ins[src_tbl[s][c-1]*W + i];
         end
      end
      return r;
   endfunction

   task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_sh = '0; m_act = '0; m_cnt = 0; m_err = 1'b0; m_reg = '0;
      end else begin
         m_reg = route_all(m_act, ins_vec());
         if (cfg_commit) begin
            if (m_cnt == CB) begin
               m_act = m_sh; m_cnt = 0; m_err = 1'b0;
            end else begin
               m_err = 1'b1;
            end
         end else if (cfg_en) begin
            m_sh = {m_sh[CB-2:0], cfg_in};
            if (m_cnt < CB) m_cnt++;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("out_comb", {if0.out_b, if0.out_t, if0.out_r, if0.out_l},
             route_all(m_act, ins_vec()));
         chk("out_reg", {if1.out_b, if1.out_t, if1.out_r, if1.out_l}, m_reg);
         chk("cfg_out", if0.cfg_out, m_sh[CB-1]);
         chk("cfg_full", if0.cfg_full, m_cnt == CB);
         chk("cfg_err", if0.cfg_err, m_err);
         chk("cfg_full_r", if1.cfg_full, m_cnt == CB);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic shift_bits(logic [CB-1:0] w, int hi, int lo);
      for (int k = hi; k >= lo; k--) begin
         cfg_in = w[k];
         cfg_en = 1'b1;
         tick();
      end
      cfg_en = 1'b0;
   endtask

   task automatic commit();
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
   endtask

   logic [47:0]   pat;
   logic [CB-1:0] w;
   int            r;

   initial begin
      // 1: reset with all inputs high
      in_l = '1; in_r = '1; in_t = '1; in_b = '1;
      #12;
      chk("rst_out0", {if0.out_b, if0.out_t, if0.out_r, if0.out_l}, 0);
      chk("rst_out1", {if1.out_b, if1.out_t, if1.out_r, if1.out_l}, 0);
      chk("rst_full", if0.cfg_full, 0);
      chk("rst_err", if0.cfg_err, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // 2: out_r[0] from L
      w = 24'h000040;
      shift_bits(w, CB-1, 0);
      chk("t2_full", if0.cfg_full, 1);
      commit();
      chk("t2_full_drop", if0.cfg_full, 0);
      in_l = 3'b110;
      #1;
      chk("t2_r0_lo", if0.out_r, 3'b000);
      chk("t2_others", {if0.out_b, if0.out_t, if0.out_l}, 0);
      in_l = 3'b111;
      #1;
      chk("t2_r0_hi", if0.out_r, 3'b001);
      chk("t2_others2", {if0.out_b, if0.out_t, if0.out_l}, 0);

      // 3: short commit then completion
      w = 24'h000008;
      shift_bits(w, CB-1, 14);
      commit();
      chk("t3_err", if0.cfg_err, 1);
      chk("t3_keep", if0.out_r, 3'b001);
      shift_bits(w, 13, 0);
      commit();
      chk("t3_err_clr", if0.cfg_err, 0);
      chk("t3_new_r", if0.out_r, 3'b000);
      chk("t3_new_l", if0.out_l, 3'b010);

      // 4: 48-bit stream through the chain
      pat = {$urandom(), $urandom()};
      pat[25] = ~pat[24];
      for (int n = 1; n <= 48; n++) begin
         if (n >= 25) chk("t4_scan", if0.cfg_out, pat[n-25]);
         cfg_in = pat[n-1];
         cfg_en = 1'b1;
         tick();
         if (n >= 24) chk("t4_full", if0.cfg_full, 1);
      end

      // 5: enable and commit together: no shift
      cfg_in = ~pat[24];
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      cfg_en = 1'b0;
      chk("t5_full", if0.cfg_full, 0);
      chk("t5_noshift", if0.cfg_out, pat[24]);
      for (int k = 0; k < CB; k++) begin
         chk("t5_shadow", if0.cfg_out, pat[24+k]);
         cfg_in = 1'b0;
         cfg_en = 1'b1;
         tick();
      end
      cfg_en = 1'b0;

      // 6: registered output latency, then async reset
      w = 24'hC00000;
      shift_bits(w, CB-1, 0);
      commit();
      in_t = 3'b000;
      tick();
      in_t = 3'b100;
      #1;
      chk("t6_comb", if0.out_b, 3'b100);
      chk("t6_reg_old", if1.out_b, 3'b000);
      tick();
      chk("t6_reg_new", if1.out_b, 3'b100);
      in_t = 3'b000;
      tick();
      chk("t6_reg_lo", if1.out_b, 3'b000);
      in_t = 3'b111;
      tick();
      shift_bits(w, CB-1, CB-5);
      commit();
      chk("t6_err_pre", if0.cfg_err, 1);
      chk("t6_out_pre", if1.out_b, 3'b100);
      cfg_in = 1'b1;
      cfg_en = 1'b1;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_out0", {if0.out_b, if0.out_t, if0.out_r, if0.out_l}, 0);
      chk("t6_rst_out1", {if1.out_b, if1.out_t, if1.out_r, if1.out_l}, 0);
      chk("t6_rst_full", if0.cfg_full, 0);
      chk("t6_rst_err", if0.cfg_err, 0);
      chk("t6_rst_scan", if0.cfg_out, 0);
      cfg_en = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      shift_bits(w, CB-1, CB-3);
      commit();
      chk("t6_partial_err", if0.cfg_err, 1);

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         in_l = W'($urandom());
         in_r = W'($urandom());
         in_t = W'($urandom());
         in_b = W'($urandom());
         r = int'($urandom_range(0, 99));
         cfg_in = 1'($urandom());
         cfg_commit = (r < 4);
         cfg_en = (r < 80) || (r == 99);
         if (r == 98 && c > 100) begin
            #2;
            rst_n = 1'b0;
            #1;
            chk("rnd_rst", {if1.out_b, if1.out_t, if1.out_r, if1.out_l}, 0);
            rst_n = 1'b1;
         end
         tick();
      end
      cfg_en = 1'b0;
      cfg_commit = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
